hht_control: RTL and testbench



---
 rtl/hht_pkg.sv | 13 +
 rtl/hht_gather_pipe.sv | 53 +++++
 rtl/hht_control.sv | 109 ++++++++++
 tb/tb_hht_control.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hht_pkg.sv
// Shared types and defaults for the HHT column-gather sequencer.
package hht_pkg;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } hht_state_e;

endpackage

// File: rtl/hht_gather_pipe.sv
// Index capture, port-2 address generation and gathered-value accumulator.
module hht_gather_pipe
  import hht_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          capture_i,
  input  logic [AW-1:0] v_base_i,
  input  logic [DW-1:0] data1_i,
  input  logic [DW-1:0] data2_i,
  output logic [AW-1:0] addr2_o,
  output logic [DW-1:0] sum_o
);

  logic [AW-1:0] addr2_q, addr2_d;
  logic          v2_q, v2_d;
  logic [DW-1:0] sum_q, sum_d;

  always_comb begin
    addr2_d = addr2_q;
    v2_d    = v2_q;
    sum_d   = sum_q;
    if (clear_i) begin
      sum_d = '0;
      v2_d  = 1'b0;
    end else begin
      // v2 marks that addr2 holds a live entry whose data2 is valid this cycle
      if (v2_q) sum_d = sum_q + data2_i;
      v2_d = capture_i;
      if (capture_i) addr2_d = v_base_i + AW'(data1_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr2_q <= '0;
      v2_q    <= 1'b0;
      sum_q   <= '0;
    end else begin
      addr2_q <= addr2_d;
      v2_q    <= v2_d;
      sum_q   <= sum_d;
    end
  end

  assign addr2_o = addr2_q;
  assign sum_o   = sum_q;

endmodule

// File: rtl/hht_control.sv
// Column-gather sequencer: walks csize index words and sums the vector entries they select.
//   state | meaning
//   IDLE  | waiting for RD; latches bases and csize on start
//   RUN   | issuing addr1 per entry, plus one drain cycle for the last addr2
//   DONE  | sum final and held until RD falls
module hht_control
  import hht_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          Clk,
  input  logic [AW-1:0] v_values_base,
  input  logic [AW-1:0] wdata_col_base,
  output logic [AW-1:0] addr1,
  output logic [AW-1:0] addr2,
  input  logic [DW-1:0] dataIn1,
  input  logic [DW-1:0] dataIn2,
  input  logic          Rst,
  input  logic [31:0]   csize,
  input  logic          RD,
  output logic [DW-1:0] sum,
  output logic          busy,
  output logic          done
);

  hht_state_e    state_q, state_d;
  logic [AW-1:0] addr1_q, addr1_d;
  logic [AW-1:0] vbase_q, vbase_d;
  logic [31:0]   rem_q, rem_d;
  logic          busy_q, done_q;
  logic          clear, capture;

  always_comb begin
    state_d = state_q;
    addr1_d = addr1_q;
    vbase_d = vbase_q;
    rem_d   = rem_q;
    clear   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (RD) begin
          vbase_d = v_values_base;
          clear   = 1'b1;
          if (csize == 32'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            addr1_d = wdata_col_base;
            rem_d   = csize;
          end
        end
      end
      ST_RUN: begin
        // rem counts entries still to issue; zero means this is the drain cycle
        if (rem_q != 32'd0) begin
          capture = 1'b1;
          rem_d   = rem_q - 32'd1;
          if (rem_q != 32'd1) addr1_d = addr1_q + AW'(1);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!RD) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      addr1_q <= '0;
      vbase_q <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr1_q <= addr1_d;
      vbase_q <= vbase_d;
      rem_q   <= rem_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  hht_gather_pipe #(
    .AW(AW),
    .DW(DW)
  ) u_pipe (
    .clk_i    (Clk),
    .rst_i    (Rst),
    .clear_i  (clear),
    .capture_i(capture),
    .v_base_i (vbase_q),
    .data1_i  (dataIn1),
    .data2_i  (dataIn2),
    .addr2_o  (addr2),
    .sum_o    (sum)
  );

  assign addr1 = addr1_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_hht_control.sv
// Scoreboard bench for hht_control: a gather model fills queues, a negedge monitor checks them.
module tb_hht_control;

  logic        Clk;
  logic [31:0] v_values_base, wdata_col_base;
  logic [31:0] addr1, addr2;
  logic [31:0] dataIn1, dataIn2;
  logic        Rst;
  logic [31:0] csize;
  logic        RD;
  logic [31:0] sum;
  logic        busy, done;

  logic [31:0] mem1 [1024];
  logic [31:0] mem2 [1024];

  assign dataIn1 = mem1[addr1[9:0]];
  assign dataIn2 = mem2[addr2[9:0]];

  hht_control #(.AW(32), .DW(32)) dut (
    .Clk           (Clk),
    .v_values_base (v_values_base),
    .wdata_col_base(wdata_col_base),
    .addr1         (addr1),
    .addr2         (addr2),
    .dataIn1       (dataIn1),
    .dataIn2       (dataIn2),
    .Rst           (Rst),
    .csize         (csize),
    .RD            (RD),
    .sum           (sum),
    .busy          (busy),
    .done          (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] sum;
    logic [31:0] a1;
    logic [31:0] a2;
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] a1_q[$];
  logic [31:0] a2_q[$];
  logic [31:0] last_a1, last_a2;
  int          checks, errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain gather over the bench memories, wrapping mod 2^32.
  task automatic push_model(input logic [31:0] col, input logic [31:0] vb, input int cs);
    exp_t        e;
    logic [31:0] s, a1, a2;
    s = 32'd0;
    for (int i = 0; i < cs; i++) begin
      a1 = col + 32'(i);
      a2 = vb + mem1[a1[9:0]];
      s  = s + mem2[a2[9:0]];
      a1_q.push_back(a1);
      a2_q.push_back(a2);
      last_a1 = a1;
      last_a2 = a2;
    end
    e.sum    = s;
    e.a1     = last_a1;
    e.a2     = last_a2;
    e.cycles = (cs == 0) ? 0 : cs + 1;
    exp_q.push_back(e);
  endtask

  int run_cnt;
  bit done_prev;

  always @(negedge Clk) begin
    exp_t        e;
    logic [31:0] x;
    if (Rst) begin
      run_cnt   = 0;
      done_prev = 1'b0;
    end else begin
      if (busy) begin
        if (run_cnt == 0 && exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start actual=busy required=idle");
        end
        if (a1_q.size() > 0) begin
          x = a1_q.pop_front();
          check("addr1_seq", addr1, x);
        end
        if (run_cnt > 0 && a2_q.size() > 0) begin
          x = a2_q.pop_front();
          check("addr2_seq", addr2, x);
        end
        run_cnt++;
      end
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=done required=no_done");
        end else begin
          e = exp_q.pop_front();
          check("sum", sum, e.sum);
          check("run_cycles", 32'(run_cnt), 32'(e.cycles));
          check("addr1_final", addr1, e.a1);
          check("addr2_final", addr2, e.a2);
          check("leftover_addrs", 32'(a1_q.size() + a2_q.size()), 32'd0);
        end
        run_cnt = 0;
      end
      done_prev = done;
    end
  end

  task automatic run_walk(input logic [31:0] col, input logic [31:0] vb, input int cs,
                          input int hold, input bit scramble);
    int n;
    push_model(col, vb, cs);
    wdata_col_base = col;
    v_values_base  = vb;
    csize          = 32'(cs);
    RD             = 1'b1;
    @(posedge Clk); #1;
    if (scramble) begin
      wdata_col_base = $urandom;
      v_values_base  = $urandom;
      csize          = $urandom_range(0, 200);
    end
    n = 0;
    while (!done && n < cs + 10) begin
      @(posedge Clk); #1;
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=no_done required=done");
    end
    check("done_latency", 32'(n), (cs == 0) ? 32'd0 : 32'(cs + 1));
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); #1;
      check("done_hold", {30'd0, busy, done}, 32'd1);
    end
    RD = 1'b0;
    @(posedge Clk); #1;
    check("done_clear", {31'd0, done}, 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_addr1"}, addr1, 32'd0);
    check({tag, "_addr2"}, addr2, 32'd0);
    check({tag, "_sum"}, sum, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  int n;

  initial begin
    checks = 0; errors = 0;
    last_a1 = 32'd0; last_a2 = 32'd0;
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = $urandom;
      mem2[i] = $urandom;
    end
    Rst = 1'b1; RD = 1'b0;
    csize = 32'd0; wdata_col_base = 32'd0; v_values_base = 32'd0;
    repeat (2) @(posedge Clk);
    #1;
    check_zero_outputs("reset");
    Rst = 1'b0;

    // csize = 0: done one cycle after start, nothing moves
    run_walk(32'd500, 32'd7, 0, 1, 1'b0);
    check("zero_sum", sum, 32'd0);
    check("zero_addr1", addr1, 32'd0);
    check("zero_addr2", addr2, 32'd0);

    // short walk from the reference example; RD held in DONE must not restart
    mem1[180] = 32'd1; mem1[181] = 32'd13; mem1[182] = 32'd12; mem1[183] = 32'd6;
    begin
      int tbl[16] = '{48, 81, 69, 93, 68, 98, 14, 85, 54, 37, 39, 1, 24, 89, 66, 5};
      for (int i = 0; i < 16; i++) mem2[2 + i] = 32'(tbl[i]);
    end
    run_walk(32'd180, 32'd2, 4, 4, 1'b0);
    check("short_sum", sum, 32'd208);

    // full 102-entry column mapped into the same table
    for (int i = 184; i <= 281; i++) mem1[i] = $urandom_range(0, 15);
    run_walk(32'd180, 32'd2, 102, 0, 1'b0);
    check("full_addr1_end", addr1, 32'd281);

    // sum wraps modulo 2^32
    mem1[600] = 32'd5; mem1[601] = 32'd6;
    mem2[905] = 32'hFFFF_FFFF; mem2[906] = 32'hFFFF_FFFF;
    run_walk(32'd600, 32'd900, 2, 1, 1'b0);
    check("wrap_sum", sum, 32'hFFFF_FFFE);

    // abort at k=2, then restart with RD still high
    push_model(32'd300, 32'd40, 10);
    wdata_col_base = 32'd300; v_values_base = 32'd40; csize = 32'd10; RD = 1'b1;
    repeat (3) begin
      @(posedge Clk); #1;
    end
    check("abort_k2_addr1", addr1, 32'd302);
    Rst = 1'b1;
    exp_q.delete(); a1_q.delete(); a2_q.delete();
    last_a1 = 32'd0; last_a2 = 32'd0;
    @(posedge Clk); #1;
    check_zero_outputs("abort");
    push_model(32'd300, 32'd40, 10);
    Rst = 1'b0;
    @(posedge Clk); #1;
    check("restart_busy", {31'd0, busy}, 32'd1);
    check("restart_addr1", addr1, 32'd300);
    n = 0;
    while (!done && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    check("restart_latency", 32'(n), 32'd11);
    RD = 1'b0;
    @(posedge Clk); #1;

    // random walks with inputs disturbed while running
    for (int t = 0; t < 8; t++) begin
      run_walk($urandom_range(0, 900), $urandom, $urandom_range(1, 20),
               $urandom_range(0, 2), 1'b1);
    end

    repeat (3) @(posedge Clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
